// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Registers: TXDATA (+0), STATUS (+4), CTRL (+8), reserved (+C).
module uart_tx_mmio #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int              CLK_DIV    = 868,
    parameter int              FIFO_DEPTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_load,
    input  logic            mem_store,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_data,
    output logic            sel,
    output logic            txd,
    output logic            irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            irq_en;
    logic            overflow;

    logic            hit;
    logic [1:0]      off;
    logic            wr_en;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic            busy;
    logic [XLEN-1:0] rdata;
    logic            unused_bits;

    assign hit      = (address[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign sel      = hit;
    assign off      = address[3:2];
    assign wr_en    = mem_store & hit;
    assign push_req = wr_en & (off == 2'd0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign pop      = (state == IDLE) & ~empty;
    assign push     = push_req & (~full | pop);
    assign irq      = irq_en & empty & ~busy;

    assign unused_bits = ^{address[1:0], store_data[XLEN-1:8]};

    // FIFO bookkeeping plus the overflow and interrupt-enable registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
            else if (wr_en && off == 2'd1) overflow <= 1'b0;
            if (wr_en && off == 2'd2) irq_en <= store_data[0];
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= store_data[7:0];
    end

    // Serialiser: txd is registered and updated together with the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        shift <= mem[rd_ptr];
                        baud  <= BAUD_LOAD;
                        txd   <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud == '0) begin
                        baud    <= BAUD_LOAD;
                        bit_idx <= '0;
                        txd     <= shift[0];
                        state   <= DATA;
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                DATA: begin
                    if (baud == '0) begin
                        baud <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud <= baud - BW'(1);
                    end
                end
                STOP: begin
                    if (baud == '0) state <= IDLE;
                    else baud <= baud - BW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-latency read mux
    always_comb begin
        rdata = '0;
        case (off)
            2'd1: begin
                rdata[0]      = full;
                rdata[1]      = empty;
                rdata[2]      = busy;
                rdata[3]      = overflow;
                rdata[8 +: CW] = count;
            end
            2'd2:    rdata[0] = irq_en;
            default: rdata = '0;
        endcase
        load_data = (hit && mem_load && !reset) ? rdata : '0;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: register, framing, overflow, irq and reset-abort checks,
// plus random bursts decoded by a serial receiver model.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int DIV = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_load = 1'b0;
    logic        mem_store = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] store_data = '0;
    logic [31:0] load_data;
    logic        sel;
    logic        txd;
    logic        irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    uart_tx_mmio #(
        .XLEN(32), .BASE_ADDR(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(8)
    ) dut (
        .clock(clock), .reset(reset), .mem_load(mem_load),
        .mem_store(mem_store), .address(address),
        .store_data(store_data), .load_data(load_data),
        .sel(sel), .txd(txd), .irq(irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Serial receiver model: samples each bit in its middle cycle
    bit         rx_on = 0;
    int         rx_t = 0;
    logic [7:0] rx_b = '0;
    always @(negedge clock) begin
        if (reset) begin
            rx_on = 0;
        end else if (!rx_on) begin
            if (txd === 1'b0) begin
                rx_on = 1;
                rx_t = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t >= DIV + DIV / 2 && rx_t < 9 * DIV &&
                (rx_t - DIV - DIV / 2) % DIV == 0)
                rx_b[(rx_t - DIV - DIV / 2) / DIV] = txd;
            if (rx_t == 9 * DIV + DIV / 2) begin
                chk("rx_stop", txd, 1);
                if (exp_q.size() == 0) chk("rx_extra", rx_b, 32'hdead);
                else chk("rx_byte", rx_b, exp_q.pop_front());
                rx_on = 0;
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        mem_load = 1'b0;
        address = a;
        store_data = d;
        mem_store = 1'b1;
        @(posedge clock);
        #1 mem_store = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d,
                      output logic s);
        @(negedge clock);
        address = a;
        mem_load = 1'b1;
        #1;
        d = load_data;
        s = sel;
    endtask

    task automatic wait_idle(input int lim);
        logic [31:0] d;
        logic s;
        int n;
        n = 0;
        do begin
            rd(BASE + 4, d, s);
            n++;
        end while (d[2:0] !== 3'b010 && n < lim);
        chk("idle_wait", d[2:0], 3'b010);
    endtask

    // Called right after store(); checks one complete frame cycle by cycle
    task automatic expect_frame(input logic [7:0] b, input bit en);
        logic e;
        @(negedge clock);
        address = BASE + 4;
        mem_load = 1'b1;
        #1 chk("irq_push", irq, 0);
        for (int k = 0; k < 10 * DIV; k++) begin
            @(negedge clock);
            #1;
            if (k < DIV) e = 1'b0;
            else if (k < 9 * DIV) e = b[(k - DIV) / DIV];
            else e = 1'b1;
            chk("txd", txd, e);
            chk("busy", load_data[2], 1);
            chk("irq_frame", irq, 0);
            if (k == 12) begin
                address = BASE;
                #1 chk("rd_txdata", load_data, 0);
                address = BASE + 4;
            end
        end
        @(negedge clock);
        #1;
        chk("post_status", load_data, 32'h002);
        chk("post_irq", irq, en);
        chk("post_txd", txd, 1);
    endtask

    initial begin
        logic [31:0] d;
        logic s;
        int len;
        logic [7:0] b;

        // Reset behaviour
        repeat (3) @(negedge clock);
        address = BASE + 4;
        mem_load = 1'b1;
        #1;
        chk("rst_load", load_data, 0);
        chk("rst_txd", txd, 1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("txd_idle", txd, 1);
        chk("irq_idle", irq, 0);
        rd(BASE + 4, d, s);
        chk("status_rst", d, 32'h002);
        chk("sel_in", s, 1);
        rd(BASE + 32'h10, d, s);
        chk("sel_out", s, 0);
        chk("load_out", d, 0);
        rd(BASE + 32'hC, d, s);
        chk("rd_resv", d, 0);

        // Single frame
        exp_q.push_back(8'hA5);
        store(BASE, 32'hFFFF_FFA5);
        expect_frame(8'hA5, 1'b0);

        // Store outside the window
        store(BASE + 32'h10, 32'h77);
        rd(BASE + 4, d, s);
        chk("out_store", d, 32'h002);
        rd(BASE + 32'h10, d, s);
        chk("out_sel", s, 0);
        chk("out_load", d, 0);

        // Overflow: 10 back-to-back pushes
        for (int i = 0; i < 10; i++) begin
            if (i < 9) exp_q.push_back(8'(8'h10 + i));
            store(BASE, 32'(8'h10 + i));
        end
        rd(BASE + 4, d, s);
        chk("ovf_status", d, 32'h80D);
        store(BASE + 4, 32'h0);
        rd(BASE + 4, d, s);
        chk("ovf_clear", d, 32'h805);
        wait_idle(600);
        chk("ovf_drained", exp_q.size(), 0);

        // Interrupt
        store(BASE + 8, 32'hFFFF_FFFF);
        rd(BASE + 8, d, s);
        chk("ctrl_rd", d, 1);
        chk("irq_en_idle", irq, 1);
        exp_q.push_back(8'h81);
        store(BASE, 32'h81);
        expect_frame(8'h81, 1'b1);
        exp_q.push_back(8'h5E);
        store(BASE, 32'h5E);
        expect_frame(8'h5E, 1'b1);
        store(BASE + 8, 32'h0);
        rd(BASE + 8, d, s);
        chk("ctrl_off", d, 0);
        chk("irq_off", irq, 0);

        // Reset in the middle of a frame
        store(BASE, 32'h00);
        repeat (15) @(negedge clock);
        #1 chk("pre_abort_txd", txd, 0);
        #1 reset = 1'b1;
        #1 chk("abort_txd", txd, 1);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        rd(BASE + 4, d, s);
        chk("abort_status", d, 32'h002);
        exp_q.push_back(8'h3C);
        store(BASE, 32'h3C);
        expect_frame(8'h3C, 1'b0);

        // Random bursts through the receiver model
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clock);
            len = $urandom_range(1, 8);
            starts.delete();
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                store(BASE, {24'($urandom), b});
            end
            rd(BASE + 4, d, s);
            chk("burst_count", d[11:8], (len == 1) ? 1 : len - 1);
            wait_idle(9 * 10 * DIV + 50);
            chk("burst_frames", starts.size(), len);
            for (int i = 1; i < starts.size(); i++)
                chk("frame_gap", starts[i] - starts[i - 1], 10 * DIV + 1);
        end

        repeat (4) @(negedge clock);
        chk("rx_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data port, downstream of the core's MEM stage. It consumes `mem_load`, `mem_store`, `address` and `store_data`. It returns `load_data` combinationally in the same cycle, as the load unit requires. Bytes stored to it are queued in a FIFO and serialised 8N1 on `txd`. Status and interrupt-enable registers sit in a 16-byte window.

## Interface
Parameters:
- `XLEN`, 32, data/address width
- `BASE_ADDR`, 32'h1000_0000, window base; bits [3:0] must be 0
- `CLK_DIV`, 868, clock cycles per bit; minimum 2
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, 2 to 64

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mem_load`  in  1  data-port load strobe
- `mem_store`  in  1  data-port store strobe
- `address`  in  XLEN  data-port address
- `store_data`  in  XLEN  store data; byte lane 0 is used
- `load_data`  out  XLEN  read data, combinational
- `sel`  out  1  `address` is inside this block's window; drives the top-level load mux
- `txd`  out  1  serial output; idle level is 1
- `irq`  out  1  TX-done interrupt

## Operation
- Window decode: `hit = (address[XLEN-1:4] == BASE_ADDR[XLEN-1:4])`. `sel = hit`. Register offset is `address[3:2]`.
- Register map:
  - Offset 0x0, TXDATA (write-only): pushes `store_data[7:0]`; reads as 0.
  - Offset 0x4, STATUS (read): bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits [8 +: log2(FIFO_DEPTH)+1] FIFO count. Any write to STATUS clears overflow.
  - Offset 0x8, CTRL (read/write): bit0 `irq_en`; all other bits read 0.
  - Offset 0xC: reads 0; writes are ignored.
- Reads: `load_data` = selected register when `hit && mem_load`, otherwise 0.
- Writes: take effect at the rising edge where `mem_store && hit`. Stores outside the window are ignored.
- Push rule: a push is accepted when `!full || pop` in that cycle; a simultaneous push and pop leaves the count unchanged. A push to a full FIFO with no pop is dropped and sets overflow (sticky).
- FIFO: circular, with read and write pointers that wrap modulo `FIFO_DEPTH` and a separate count register.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop into an 8-bit shift register, load the baud counter with `CLK_DIV-1`, and go to START.
  - START: `txd=0`. When the baud counter reaches 0, reload the counter, set bit index to 0, and go to DATA.
  - DATA: `txd = shift[0]`. At each counter expiry, shift right and increment the bit index; after bit 7 expires, go to STOP.
  - STOP: `txd=1`. At counter expiry, go to IDLE.
- `busy = (state != IDLE)`.
- `irq = irq_en & empty & ~busy`, decoded from registered state only (no combinational path from bus inputs).
- `txd` is a registered output.

## Timing
- Reset values: `txd=1`, FSM in IDLE, FIFO empty (count 0, pointers 0), `irq_en=0`, overflow=0, `irq=0`, shift register 0.
- Reset also forces `load_data=0` and `sel` to follow `address`.
- STATUS reads 0x002 after reset.
- Push at edge N. The FSM pops at edge N+1, and `txd` falls after edge N+1.
- Frame length is exactly `10*CLK_DIV` cycles: START, 8 data bits LSB-first, then STOP.
- Back-to-back frames have one IDLE cycle between the end of STOP and the next START.
- Reset asserted mid-frame: `txd` returns to 1 immediately (asynchronously), the frame is aborted, and the FIFO is flushed. Transmission resumes normally after reset deasserts.
- Reads have zero latency. A write followed by a read of the same register in the next cycle returns the new value.

## Test plan
- Reset: after deassertion, `txd=1` and `irq=0`; a load from BASE+4 returns 0x002; `sel=1` for BASE+4 and `sel=0` for BASE+0x10.
- CLK_DIV=4, store 0xA5 to BASE+0 at edge N:
  - `txd` goes 0 for cycles N+1..N+4.
  - Then it carries bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for the stop bit.
  - STATUS busy=1 for 40 cycles, then busy=0 and empty=1.
- Overflow (DEPTH=8): store 10 bytes back-to-back. Byte 1 is popped, bytes 2–9 fill the FIFO (full=1, count=8), and byte 10 is dropped with overflow=1. A write to BASE+4 clears overflow.
- Interrupt: write CTRL=1 and send one byte; `irq` rises after the STOP bit. A new store to TXDATA drops `irq` after the push edge.
- Reset at cycle 15 of a frame: `txd=1` immediately and STATUS=0x002. A following store of 0x3C transmits a correct frame.
- Window edges:
  - A load from BASE+0xC returns 0.
  - A store to BASE+0x10 leaves the FIFO count at 0, with `sel=0` and `load_data=0`.
  - A load from BASE+0 returns 0 while a frame is active.
